palette_arbiter: RTL and testbench

Owns the 32-entry PPU palette memory and arbitrates its single access slot per cycle between the pixel pipeline and the CPU register interface. The 6-bit palette entry it returns for each pixel feeds the palette-index-to-RGB colour decoder that drives VGA. It applies NES palette mirroring, selects the backdrop for transparent pixels and bounds CPU wait time during rendering.

---
 rtl/palette_arbiter.sv | 137 +++++++++++++
 tb/tb_palette_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_arbiter.sv
// palette_arbiter: 32 x 6 NES palette RAM with one access slot per cycle,
// shared between the pixel pipeline (1-cycle lookups) and the CPU port
// (captured request, bounded wait, one-cycle ack).
// Optional feature: define PALETTE_GREYSCALE_EN to add the greyscale input,
// which masks pixel results to the luma bits.
module palette_arbiter #(
  parameter int MAX_WAIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rendering,
  input  logic       pix_req,
  input  logic [4:0] pix_index,
  output logic       pix_valid,
  output logic [5:0] pix_color,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [4:0] cpu_addr,
  input  logic [5:0] cpu_wdata,
  output logic       cpu_ack,
  output logic [5:0] cpu_rdata
`ifdef PALETTE_GREYSCALE_EN
  ,
  input  logic       greyscale
`endif
);

  typedef enum logic [1:0] {IDLE, PEND, ACK} state_t;

  typedef struct packed {
    logic       we;
    logic [4:0] addr;
    logic [5:0] wdata;
  } cpu_op_t;

  // Last wait count before the CPU is forced into the slot.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t           state, state_nxt;
  logic [7:0]       wait_cnt, wait_nxt;
  logic             capture;
  cpu_op_t          op;
  logic [31:0][5:0] mem;
  logic             cpu_grant, pix_grant;
  logic [4:0]       cpu_maddr, pix_maddr;
  logic [5:0]       pix_mask;

  // Entries x0/x4/x8/xC of the sprite half alias the background half.
  function automatic logic [4:0] mirror(input logic [4:0] a);
    logic [4:0] m;
    m = a;
    if (a[1:0] == 2'b00) m[4] = 1'b0;
    return m;
  endfunction

  // Slot arbitration: CPU takes it from PEND when the pixel side is idle,
  // rendering is off, or the wait budget is spent.
  assign cpu_grant = (state == PEND) &&
                     (!rendering || !pix_req || (wait_cnt == WAIT_LAST));
  assign pix_grant = pix_req && !cpu_grant;

  // Transparent pixels (colour 0) show the backdrop at entry 0x00.
  assign pix_maddr = (pix_index[1:0] == 2'b00) ? 5'h00 : mirror(pix_index);
  assign cpu_maddr = mirror(op.addr);

`ifdef PALETTE_GREYSCALE_EN
  assign pix_mask = greyscale ? 6'h30 : 6'h3F;
`else
  assign pix_mask = 6'h3F;
`endif

  // CPU FSM state, wait counter and captured operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
      op       <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (capture) op <= '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
    end
  end

  // CPU FSM next state and ack.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    capture   = 1'b0;
    cpu_ack   = 1'b0;
    case (state)
      IDLE: begin
        wait_nxt = 8'd0;
        if (cpu_req) begin
          capture   = 1'b1;
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (cpu_grant) state_nxt = ACK;
        else           wait_nxt  = 8'(wait_cnt + 8'd1);
      end
      ACK: begin
        cpu_ack   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Palette storage; CPU writes commit on the grant edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 6'h0F;
    end else if (cpu_grant && op.we) begin
      mem[cpu_maddr] <= op.wdata;
    end
  end

  // CPU read data, sampled from storage at the grant edge.
  always_ff @(posedge clk) begin
    if (reset)                    cpu_rdata <= 6'h00;
    else if (cpu_grant && !op.we) cpu_rdata <= mem[cpu_maddr];
  end

  // Pixel result register; colour holds when the lookup loses the slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_valid <= 1'b0;
      pix_color <= 6'h00;
    end else begin
      pix_valid <= pix_grant;
      if (pix_grant) pix_color <= mem[pix_maddr] & pix_mask;
    end
  end

endmodule

// File: tb/tb_palette_arbiter.sv
// Self-checking bench for palette_arbiter: directed scenarios from the test
// plan plus randomized CPU/pixel traffic against a behavioural palette model.
`timescale 1ns/1ps
module tb_palette_arbiter;
  localparam int MAX_WAIT = 16;

  logic       clk = 1'b0;
  logic       reset, rendering, pix_req, cpu_req, cpu_we;
  logic [4:0] pix_index, cpu_addr;
  logic [5:0] cpu_wdata;
  logic       pix_valid, cpu_ack;
  logic [5:0] pix_color, cpu_rdata;
`ifdef PALETTE_GREYSCALE_EN
  logic       greyscale;
`endif

  int errors = 0;
  int checks = 0;

  // Behavioural palette contents, indexed by physical entry.
  logic [5:0] model [32];

  palette_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .rendering(rendering),
    .pix_req(pix_req), .pix_index(pix_index),
    .pix_valid(pix_valid), .pix_color(pix_color),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata)
`ifdef PALETTE_GREYSCALE_EN
    , .greyscale(greyscale)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // Physical entry addressed by a CPU address.
  function automatic int mir(input int a);
    return (a % 4 == 0) ? (a % 16) : a;
  endfunction

  // Physical entry read by a pixel lookup.
  function automatic int pix_entry(input int i);
    return (i % 4 == 0) ? 0 : i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 6'h0F;
  endtask

  // Uncontended-or-not CPU access; returns cycles until ack seen and rdata.
  task automatic cpu_access(input logic we, input logic [4:0] addr,
                            input logic [5:0] wdata,
                            output int lat, output logic [5:0] rdata);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (cpu_ack !== 1'b1 && lat < MAX_WAIT + 8);
    rdata   = cpu_rdata;
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; rendering = 1'b0; pix_req = 1'b0; pix_index = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
`ifdef PALETTE_GREYSCALE_EN
    greyscale = 1'b0;
`endif
    tick(); tick();
    model_reset();
    checks++;
    if ({pix_valid, pix_color, cpu_ack, cpu_rdata} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b color=%h ack=%b rdata=%h, want all 0",
               pix_valid, pix_color, cpu_ack, cpu_rdata);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (pix_valid !== 1'b0 || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got valid=%b ack=%b, want 0 0", pix_valid, cpu_ack);
    end
  endtask

  task automatic test_pixel_sweep();
    rendering = 1'b0;
    for (int i = 0; i < 32; i++) begin
      pix_req = 1'b1; pix_index = 5'(i);
      tick();
      checks++;
      if (pix_valid !== 1'b1 || pix_color !== model[pix_entry(i)]) begin
        errors++;
        $display("FAIL sweep idx %0d: got valid=%b color=%h, want 1 %h",
                 i, pix_valid, pix_color, model[pix_entry(i)]);
      end
    end
    pix_req = 1'b0;
    tick();
    checks++;
    if (pix_valid !== 1'b0 || pix_color !== model[pix_entry(31)]) begin
      errors++;
      $display("FAIL sweep_idle: got valid=%b color=%h, want 0 %h",
               pix_valid, pix_color, model[pix_entry(31)]);
    end
  endtask

  task automatic test_mirror();
    int lat;
    logic [5:0] rd;
    cpu_access(1'b1, 5'h10, 6'h21, lat, rd);
    model[mir(5'h10)] = 6'h21;
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL mirror_write_latency: got %0d, want 2", lat);
    end
    cpu_access(1'b0, 5'h00, 6'h00, lat, rd);
    checks++;
    if (lat != 2 || rd !== 6'h21) begin
      errors++;
      $display("FAIL mirror_read: got lat=%0d rdata=%h, want 2 21", lat, rd);
    end
    pix_req = 1'b1; pix_index = 5'h05;
    tick();
    checks++;
    if (pix_color !== 6'h0F) begin
      errors++;
      $display("FAIL pix_05: got %h, want 0f", pix_color);
    end
    pix_index = 5'h04;
    tick();
    checks++;
    if (pix_color !== 6'h21) begin
      errors++;
      $display("FAIL pix_04_backdrop: got %h, want 21", pix_color);
    end
    pix_index = 5'h14;
    tick();
    checks++;
    if (pix_color !== 6'h21) begin
      errors++;
      $display("FAIL pix_14_backdrop: got %h, want 21", pix_color);
    end
    pix_req = 1'b0;
    tick();
  endtask

  task automatic test_forced_grant();
    int a;
    logic [5:0] old, nv, exp_c;
    logic exp_v, exp_a;
    for (int it = 0; it < 3; it++) begin
      do a = $urandom_range(0, 31); while (a % 4 == 0);
      old = model[a];
      nv  = old ^ 6'($urandom_range(1, 63));
      rendering = 1'b1; pix_req = 1'b1; pix_index = 5'(a);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'(a); cpu_wdata = nv;
      tick();
      checks++;
      if (pix_valid !== 1'b1 || pix_color !== old) begin
        errors++;
        $display("FAIL forced_capture: got valid=%b color=%h, want 1 %h",
                 pix_valid, pix_color, old);
      end
      for (int k = 1; k <= 17; k++) begin
        tick();
        exp_v = (k != MAX_WAIT);
        exp_a = (k == MAX_WAIT);
        exp_c = (k > MAX_WAIT) ? nv : old;
        checks++;
        if (pix_valid !== exp_v || cpu_ack !== exp_a || pix_color !== exp_c) begin
          errors++;
          $display("FAIL forced cycle %0d addr %0d: got valid=%b ack=%b color=%h, want %b %b %h",
                   k, a, pix_valid, cpu_ack, pix_color, exp_v, exp_a, exp_c);
        end
        if (k == MAX_WAIT) cpu_req = 1'b0;
      end
      model[a] = nv;
      pix_req = 1'b0; rendering = 1'b0;
      tick();
    end
  endtask

  task automatic test_cpu_priority();
    int a;
    logic [5:0] old, nv;
    do a = $urandom_range(0, 31); while (a % 4 == 0);
    old = model[a];
    nv  = old ^ 6'($urandom_range(1, 63));
    rendering = 1'b0; pix_req = 1'b1; pix_index = 5'(a);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'(a); cpu_wdata = nv;
    tick();
    checks++;
    if (pix_valid !== 1'b1 || pix_color !== old) begin
      errors++;
      $display("FAIL prio_capture: got valid=%b color=%h, want 1 %h", pix_valid, pix_color, old);
    end
    tick();
    checks++;
    if (pix_valid !== 1'b0 || pix_color !== old || cpu_ack !== 1'b1) begin
      errors++;
      $display("FAIL prio_grant: got valid=%b color=%h ack=%b, want 0 %h 1",
               pix_valid, pix_color, cpu_ack, old);
    end
    cpu_req = 1'b0;
    tick();
    model[a] = nv;
    checks++;
    if (pix_valid !== 1'b1 || pix_color !== nv || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL prio_after: got valid=%b color=%h ack=%b, want 1 %h 0",
               pix_valid, pix_color, cpu_ack, nv);
    end
    pix_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_pend();
    int lat, acks;
    logic [5:0] rd;
    rendering = 1'b1; pix_req = 1'b1; pix_index = 5'h05;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h03; cpu_wdata = 6'h2A;
    tick(); tick(); tick();
    checks++;
    if (cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL pend_no_early_ack: got ack=%b, want 0", cpu_ack);
    end
    reset = 1'b1; cpu_req = 1'b0; pix_req = 1'b0; rendering = 1'b0;
    tick();
    reset = 1'b0;
    model_reset();
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cpu_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL reset_pend_ack: got %0d acks, want 0", acks);
    end
    cpu_access(1'b0, 5'h03, 6'h00, lat, rd);
    checks++;
    if (lat != 2 || rd !== 6'h0F) begin
      errors++;
      $display("FAIL reset_pend_readback: got lat=%0d rdata=%h, want 2 0f", lat, rd);
    end
  endtask

`ifdef PALETTE_GREYSCALE_EN
  task automatic test_greyscale();
    int lat;
    logic [5:0] rd;
    cpu_access(1'b1, 5'h01, 6'h27, lat, rd);
    model[1] = 6'h27;
    greyscale = 1'b1; pix_req = 1'b1; pix_index = 5'h01;
    tick();
    checks++;
    if (pix_color !== 6'h20) begin
      errors++;
      $display("FAIL grey_pixel: got %h, want 20", pix_color);
    end
    pix_req = 1'b0;
    tick();
    cpu_access(1'b0, 5'h01, 6'h00, lat, rd);
    checks++;
    if (rd !== 6'h27) begin
      errors++;
      $display("FAIL grey_cpu_read: got %h, want 27", rd);
    end
    greyscale = 1'b0; pix_req = 1'b1;
    tick();
    checks++;
    if (pix_color !== 6'h27) begin
      errors++;
      $display("FAIL grey_off_pixel: got %h, want 27", pix_color);
    end
    pix_req = 1'b0;
    tick();
  endtask
`endif

  task automatic test_random();
    int lat, r, n, idx;
    logic [4:0] a;
    logic [5:0] d, rd, last;
    logic req;
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 2);
      rendering = 1'($urandom_range(0, 1));
      a = 5'($urandom_range(0, 31));
      d = 6'($urandom_range(0, 63));
      if (r == 0) begin
        cpu_access(1'b1, a, d, lat, rd);
        model[mir(a)] = d;
        checks++;
        if (lat != 2) begin
          errors++;
          $display("FAIL rand_write lat addr %h: got %0d, want 2", a, lat);
        end
      end else if (r == 1) begin
        cpu_access(1'b0, a, 6'h00, lat, rd);
        checks++;
        if (lat != 2 || rd !== model[mir(a)]) begin
          errors++;
          $display("FAIL rand_read addr %h: got lat=%0d rdata=%h, want 2 %h",
                   a, lat, rd, model[mir(a)]);
        end
      end else begin
        n = $urandom_range(1, 6);
        last = 6'h00;
        for (int j = 0; j < n; j++) begin
          idx = $urandom_range(0, 31);
          req = (j == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
          pix_req = req; pix_index = 5'(idx);
          tick();
          if (req) last = model[pix_entry(idx)];
          checks++;
          if (pix_valid !== req || pix_color !== last) begin
            errors++;
            $display("FAIL rand_pixel idx %0d req %b: got valid=%b color=%h, want %b %h",
                     idx, req, pix_valid, pix_color, req, last);
          end
        end
        pix_req = 1'b0;
        tick();
      end
    end
    rendering = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pixel_sweep();
    test_mirror();
    test_forced_grant();
    test_cpu_priority();
    test_reset_in_pend();
`ifdef PALETTE_GREYSCALE_EN
    test_greyscale();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
